uart_rx: RTL

UART receive engine with 16x oversampling. It consumes the one-cycle sample tick produced by the baud-rate generator (`mod_m_counter`, `max_tick` → `s_tick`) and deserializes the asynchronous `rx` line into parallel bytes. Each completed frame is delivered with a one-cycle done strobe and a framing-error flag, ready for the downstream FIFO or interface unit.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/sync_2ff.sv | 32 +++
 rtl/uart_rx.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks (uart_rx now, uart_tx later).
//   state_t       : receive/transmit FSM state encoding
//   OVERSAMPLE    : sample ticks per bit period
//   START_MID     : sample count at the middle of the start bit
//   DEF_DBIT      : default data bits per frame
//   DEF_SB_TICK   : default stop-bit length in sample ticks
//   cnt_width()   : bits needed for a counter that must reach max_val
// ---------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   localparam int OVERSAMPLE  = 16;
   localparam int START_MID   = 7;
   localparam int DEF_DBIT    = 8;
   localparam int DEF_SB_TICK = 16;

   // Width of a counter that has to hold values 0..max_val (at least 1 bit).
   function automatic int cnt_width(input int max_val);
      int w;
      w = $clog2(max_val + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous input.
//   clk   : destination clock
//   reset : synchronous, active-high; both flops load RESET_VAL
//   d     : asynchronous input
//   q     : synchronized output, 2 clk after d
// RESET_VAL lets idle-high lines (UART rx) come out of reset without a
// spurious edge.
// ---------------------------------------------------------------------------
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// UART receiver with 16x oversampling. Deserializes the idle-high rx line
// (LSB first) using the s_tick sample strobe from the baud generator.
//   clk          : system clock
//   reset        : synchronous, active-high
//   rx           : asynchronous serial input, idle high
//   s_tick       : oversampling strobe, one clk wide, 16 per bit
//   rx_done_tick : one-cycle pulse when a frame completes
//   dout         : last received word, held until the next frame completes
//   frame_err    : 1 when the last frame's stop bit was sampled low
//   state        : current FSM state (debug visibility)
//
// Interface semantics: there is no valid/ready handshake. rx_done_tick is a
// strobe; dout/frame_err change only in the cycle it is high and the consumer
// must capture them then. There is no backpressure.
// ---------------------------------------------------------------------------
module uart_rx
   import uart_pkg::*;
#(
   parameter int DBIT    = DEF_DBIT,
   parameter int SB_TICK = DEF_SB_TICK
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx,
   input  logic            s_tick,
   output logic            rx_done_tick,
   output logic [DBIT-1:0] dout,
   output logic            frame_err,
   output state_t          state
);

   // s must reach both OVERSAMPLE-1 (data bits) and SB_TICK-1 (stop bit).
   localparam int SW = cnt_width((SB_TICK > OVERSAMPLE) ? SB_TICK - 1 : OVERSAMPLE - 1);
   localparam int NW = cnt_width(DBIT - 1);

   logic            rx_s;
   logic [SW-1:0]   s, s_n;
   logic [NW-1:0]   n, n_n;
   logic [DBIT-1:0] b, b_n;
   logic [DBIT-1:0] dout_n;
   logic            frame_err_n;
   logic            done_n;
   state_t          state_n;

   sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (rx_s)
   );

   // Next-state logic
   always_comb begin
      state_n     = state;
      s_n         = s;
      n_n         = n;
      b_n         = b;
      dout_n      = dout;
      frame_err_n = frame_err;
      done_n      = 1'b0;

      case (state)
         IDLE: begin
            // The falling edge alone starts a frame; no tick needed.
            if (!rx_s) begin
               state_n = START;
               s_n     = '0;
            end
         end

         START: begin
            if (s_tick) begin
               if (s == SW'(START_MID)) begin
                  // Still low at mid start bit: real frame; high: glitch.
                  if (!rx_s) begin
                     state_n = DATA;
                     s_n     = '0;
                     n_n     = '0;
                  end else begin
                     state_n = IDLE;
                  end
               end else begin
                  s_n = s + SW'(1);
               end
            end
         end

         DATA: begin
            if (s_tick) begin
               if (s == SW'(OVERSAMPLE - 1)) begin
                  b_n = {rx_s, b[DBIT-1:1]};
                  s_n = '0;
                  if (n == NW'(DBIT - 1)) begin
                     state_n = STOP;
                  end else begin
                     n_n = n + NW'(1);
                  end
               end else begin
                  s_n = s + SW'(1);
               end
            end
         end

         STOP: begin
            if (s_tick) begin
               if (s == SW'(SB_TICK - 1)) begin
                  // Frame is delivered even with a bad stop bit.
                  dout_n      = b;
                  frame_err_n = ~rx_s;
                  done_n      = 1'b1;
                  state_n     = IDLE;
               end else begin
                  s_n = s + SW'(1);
               end
            end
         end

         default: state_n = IDLE;
      endcase
   end

   // State and output registers; reset overrides any tick in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         s            <= '0;
         n            <= '0;
         b            <= '0;
         dout         <= '0;
         frame_err    <= 1'b0;
         rx_done_tick <= 1'b0;
      end else begin
         state        <= state_n;
         s            <= s_n;
         n            <= n_n;
         b            <= b_n;
         dout         <= dout_n;
         frame_err    <= frame_err_n;
         rx_done_tick <= done_n;
      end
   end

endmodule
